dmem_arbiter: RTL

Two-port arbiter and access sequencer in front of the single-port data memory. Two requesters share the memory's one address/write port: a CPU load/store unit on port 0 and a debug/DMA loader on port 1. The block accepts level requests, picks a winner round-robin, drives one memory access, and returns read data with a one-cycle done pulse. Out-of-range addresses are rejected with an error instead of reaching memory.

---
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and single-access sequencer sharing one
// data-memory port between the CPU load/store unit (port 0) and a debug/DMA
// loader (port 1). Out-of-range accesses complete with Err instead of
// reaching memory.
module dmem_arbiter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 16
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     Req0,
    input  logic                     Req1,
    input  logic                     We0,
    input  logic                     We1,
    input  logic [ADDRESS_WIDTH-1:0] Addr0,
    input  logic [ADDRESS_WIDTH-1:0] Addr1,
    input  logic [DATA_WIDTH-1:0]    WData0,
    input  logic [DATA_WIDTH-1:0]    WData1,
    output logic                     Done0,
    output logic                     Done1,
    output logic [DATA_WIDTH-1:0]    RData,
    output logic                     Err,
    output logic                     Busy,
    output logic [ADDRESS_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0]    MemWData,
    output logic                     MemWrite,
    input  logic [DATA_WIDTH-1:0]    MemRData
);

    localparam logic [ADDRESS_WIDTH-1:0] DEPTH_A = ADDRESS_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic                     last_grant;
    logic                     id_q;
    logic                     we_q;
    logic                     oor_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    rdata_q;

    logic                     grant;
    logic                     sel_we;
    logic                     sel_oor;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;

    // Winner selection: a lone requester wins; on a tie the port not granted last wins.
    always_comb begin
        grant     = (Req0 & Req1) ? ~last_grant : Req1;
        sel_we    = grant ? We1    : We0;
        sel_addr  = grant ? Addr1  : Addr0;
        sel_wdata = grant ? WData1 : WData0;
        sel_oor   = (sel_addr >= DEPTH_A);
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode; outputs depend on state only, so reset clears them at once.
    always_comb begin
        state_nxt = state;
        Done0     = 1'b0;
        Done1     = 1'b0;
        RData     = '0;
        Err       = 1'b0;
        MemAddr   = '0;
        MemWData  = '0;
        MemWrite  = 1'b0;
        Busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (Req0 | Req1) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
                MemAddr   = addr_q;
                MemWData  = wdata_q;
                MemWrite  = we_q & ~oor_q;
            end
            RESP: begin
                state_nxt = IDLE;
                Done0     = ~id_q;
                Done1     = id_q;
                RData     = rdata_q;
                Err       = oor_q;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch on grant, read capture and grant history at the end of ACCESS.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            if (state == IDLE && (Req0 | Req1)) begin
                id_q    <= grant;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                oor_q   <= sel_oor;
            end
            if (state == ACCESS) begin
                rdata_q    <= (we_q | oor_q) ? '0 : MemRData;
                last_grant <= id_q;
            end
        end
    end

endmodule
